// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage and the decode logic
// that builds its control words.
//   - alu_op_e      : ALU operation codes carried in control word [4:0]
//   - CW_*          : bit positions inside the 32-bit control word
//   - DES_*         : field positions inside the 7-bit destination field
//   - INT_OVF       : bit of the exception control word flagged on overflow
package exe_pkg;

    // Control word layout
    localparam int CW_ALU_OP_LSB = 0;
    localparam int CW_ALU_OP_MSB = 4;
    localparam int CW_BSRC       = 5;   // 0: register B, 1: immediate
    localparam int CW_SHSRC      = 6;   // 0: immed[10:6], 1: A[4:0]
    localparam int CW_MEM_RD     = 7;
    localparam int CW_MEM_WR     = 8;
    localparam int CW_MEM_SZ_LSB = 9;
    localparam int CW_MEM_SZ_MSB = 10;
    localparam int CW_LD_UNS     = 11;
    localparam int CW_LINK       = 12;

    // Destination field layout
    localparam int DES_REG_LSB = 0;
    localparam int DES_REG_MSB = 4;
    localparam int DES_WE      = 5;
    localparam int DES_LOAD    = 6;

    // Exception control word: arithmetic overflow flag
    localparam int INT_OVF = 2;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_ADDU  = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SUBU  = 5'd3,
        ALU_AND   = 5'd4,
        ALU_OR    = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_NOR   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_SLL   = 5'd10,
        ALU_SRL   = 5'd11,
        ALU_SRA   = 5'd12,
        ALU_LUI   = 5'd13,
        ALU_MULT  = 5'd14,
        ALU_MULTU = 5'd15,
        ALU_PASSA = 5'd16,
        ALU_MTHI  = 5'd17
    } alu_op_e;

endpackage

// File: rtl/exe_alu.sv
// exe_alu: purely combinational execute datapath.
// Inputs : alu_op, b_src, sh_src, mem_access (load or store), link,
//          pc, a, b, immed (all 32-bit operands)
// Outputs: result (32), hi (32, HI register value), overflow (signed
//          ADD/SUB overflow of the ALU result actually selected)
module exe_alu
    import exe_pkg::*;
(
    input  logic [4:0]  alu_op,
    input  logic        b_src,
    input  logic        sh_src,
    input  logic        mem_access,
    input  logic        link,
    input  logic [31:0] pc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] immed,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic        overflow
);

    logic [31:0] bs;
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] alu_res;
    logic        ovf_raw;

    always_comb begin
        bs     = b_src  ? immed  : b;
        shamt  = sh_src ? a[4:0] : immed[10:6];
        sum    = a + bs;
        diff   = a - bs;
        prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{bs[31]}}, bs}));
        prod_u = {32'd0, a} * {32'd0, bs};

        alu_res = 32'd0;
        hi      = 32'd0;
        ovf_raw = 1'b0;

        case (alu_op_e'(alu_op))
            ALU_ADD: begin
                alu_res = sum;
                ovf_raw = (a[31] == bs[31]) && (sum[31] != a[31]);
            end
            ALU_ADDU:  alu_res = sum;
            ALU_SUB: begin
                alu_res = diff;
                ovf_raw = (a[31] != bs[31]) && (diff[31] != a[31]);
            end
            ALU_SUBU:  alu_res = diff;
            ALU_AND:   alu_res = a & bs;
            ALU_OR:    alu_res = a | bs;
            ALU_XOR:   alu_res = a ^ bs;
            ALU_NOR:   alu_res = ~(a | bs);
            ALU_SLT:   alu_res = {31'd0, $signed(a) < $signed(bs)};
            ALU_SLTU:  alu_res = {31'd0, a < bs};
            // Shifts always operate on the register B operand
            ALU_SLL:   alu_res = b << shamt;
            ALU_SRL:   alu_res = b >> shamt;
            ALU_SRA:   alu_res = 32'($signed(b) >>> shamt);
            ALU_LUI:   alu_res = {immed[15:0], 16'd0};
            ALU_MULT: begin
                alu_res = prod_s[31:0];
                hi      = prod_s[63:32];
            end
            ALU_MULTU: begin
                alu_res = prod_u[31:0];
                hi      = prod_u[63:32];
            end
            ALU_PASSA: alu_res = a;
            ALU_MTHI:  hi      = a;
            default:   alu_res = 32'd0;
        endcase

        // Link beats address generation, which beats the ALU op.
        // Overflow only matters when the ALU result is the one used.
        if (link) begin
            result   = pc + 32'd8;
            overflow = 1'b0;
        end else if (mem_access) begin
            result   = a + immed;
            overflow = 1'b0;
        end else begin
            result   = alu_res;
            overflow = ovf_raw;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute pipeline stage. Wraps exe_alu, masks the write
// enables on overflow and registers everything towards MEM.
// A new instruction is accepted every cycle; there is no stall or flush.
// Inputs : clk, reset (sync, active high), id_contr_word, id_int_contr_word,
//          exe_pc, exe_reg_res_A/B, exe_immed, id_des, id_wr_hilo
// Outputs (combinational, to ID forwarding): exe_alu_des, exe_alu_wr_hilo,
//          alu_2id_res, alu_2id_hilo
// Outputs (registered, to MEM): exe_res, mem_data, mem_pc, mem_hilo,
//          exe_contr_word, exe_int_contr_word, exe_des, exe_wr_hilo
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_contr_word,
    input  logic [7:0]  id_int_contr_word,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_reg_res_A,
    input  logic [31:0] exe_reg_res_B,
    input  logic [31:0] exe_immed,
    input  logic [6:0]  id_des,
    input  logic [1:0]  id_wr_hilo,
    output logic [6:0]  exe_alu_des,
    output logic [1:0]  exe_alu_wr_hilo,
    output logic [31:0] alu_2id_res,
    output logic [31:0] alu_2id_hilo,
    output logic [31:0] exe_res,
    output logic [31:0] mem_data,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_hilo,
    output logic [31:0] exe_contr_word,
    output logic [7:0]  exe_int_contr_word,
    output logic [6:0]  exe_des,
    output logic [1:0]  exe_wr_hilo
);

    logic       overflow;
    logic [7:0] int_next;

    exe_alu u_alu (
        .alu_op     (id_contr_word[CW_ALU_OP_MSB:CW_ALU_OP_LSB]),
        .b_src      (id_contr_word[CW_BSRC]),
        .sh_src     (id_contr_word[CW_SHSRC]),
        .mem_access (id_contr_word[CW_MEM_RD] | id_contr_word[CW_MEM_WR]),
        .link       (id_contr_word[CW_LINK]),
        .pc         (exe_pc),
        .a          (exe_reg_res_A),
        .b          (exe_reg_res_B),
        .immed      (exe_immed),
        .result     (alu_2id_res),
        .hi         (alu_2id_hilo),
        .overflow   (overflow)
    );

    // An overflowing instruction must not write the register file or HI/LO,
    // and ID must not forward from it either.
    always_comb begin
        exe_alu_des = id_des;
        if (overflow) begin
            exe_alu_des[DES_WE] = 1'b0;
        end
        exe_alu_wr_hilo = overflow ? 2'b00 : id_wr_hilo;
        int_next = id_int_contr_word;
        int_next[INT_OVF] = id_int_contr_word[INT_OVF] | overflow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_res            <= 32'd0;
            mem_data           <= 32'd0;
            mem_pc             <= 32'd0;
            mem_hilo           <= 32'd0;
            exe_contr_word     <= 32'd0;
            exe_int_contr_word <= 8'd0;
            exe_des            <= 7'd0;
            exe_wr_hilo        <= 2'd0;
        end else begin
            exe_res            <= alu_2id_res;
            mem_data           <= exe_reg_res_B;
            mem_pc             <= exe_pc;
            mem_hilo           <= alu_2id_hilo;
            exe_contr_word     <= id_contr_word;
            exe_int_contr_word <= int_next;
            exe_des            <= exe_alu_des;
            exe_wr_hilo        <= exe_alu_wr_hilo;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id_contr_word = '0;
    logic [7:0]  id_int_contr_word = '0;
    logic [31:0] exe_pc = '0;
    logic [31:0] exe_reg_res_A = '0;
    logic [31:0] exe_reg_res_B = '0;
    logic [31:0] exe_immed = '0;
    logic [6:0]  id_des = '0;
    logic [1:0]  id_wr_hilo = '0;
    logic [6:0]  exe_alu_des;
    logic [1:0]  exe_alu_wr_hilo;
    logic [31:0] alu_2id_res;
    logic [31:0] alu_2id_hilo;
    logic [31:0] exe_res;
    logic [31:0] mem_data;
    logic [31:0] mem_pc;
    logic [31:0] mem_hilo;
    logic [31:0] exe_contr_word;
    logic [7:0]  exe_int_contr_word;
    logic [6:0]  exe_des;
    logic [1:0]  exe_wr_hilo;

    exe_stage dut (
        .clk                (clk),
        .reset              (reset),
        .id_contr_word      (id_contr_word),
        .id_int_contr_word  (id_int_contr_word),
        .exe_pc             (exe_pc),
        .exe_reg_res_A      (exe_reg_res_A),
        .exe_reg_res_B      (exe_reg_res_B),
        .exe_immed          (exe_immed),
        .id_des             (id_des),
        .id_wr_hilo         (id_wr_hilo),
        .exe_alu_des        (exe_alu_des),
        .exe_alu_wr_hilo    (exe_alu_wr_hilo),
        .alu_2id_res        (alu_2id_res),
        .alu_2id_hilo       (alu_2id_hilo),
        .exe_res            (exe_res),
        .mem_data           (mem_data),
        .mem_pc             (mem_pc),
        .mem_hilo           (mem_hilo),
        .exe_contr_word     (exe_contr_word),
        .exe_int_contr_word (exe_int_contr_word),
        .exe_des            (exe_des),
        .exe_wr_hilo        (exe_wr_hilo)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Vector record: inputs then expected outputs
    typedef struct {
        logic [31:0] cw;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [6:0]  des;
        logic [1:0]  hilo;
        logic [7:0]  intc;
        logic [31:0] e_res;
        logic [31:0] e_hi;
        logic [6:0]  e_des;
        logic [1:0]  e_whilo;
        logic [7:0]  e_int;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic vec_t mk(
        input logic [31:0] cw, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] imm, input logic [31:0] pc, input logic [6:0] des,
        input logic [1:0] hilo, input logic [7:0] intc,
        input logic [31:0] e_res, input logic [31:0] e_hi,
        input logic [6:0] e_des, input logic [1:0] e_whilo, input logic [7:0] e_int);
        vec_t v;
        v.cw = cw; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
        v.des = des; v.hilo = hilo; v.intc = intc;
        v.e_res = e_res; v.e_hi = e_hi; v.e_des = e_des;
        v.e_whilo = e_whilo; v.e_int = e_int;
        return v;
    endfunction

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Driver
    task automatic drive(input vec_t v);
        id_contr_word     = v.cw;
        id_int_contr_word = v.intc;
        exe_pc            = v.pc;
        exe_reg_res_A     = v.a;
        exe_reg_res_B     = v.b;
        exe_immed         = v.imm;
        id_des            = v.des;
        id_wr_hilo        = v.hilo;
    endtask

    task automatic check_comb(input vec_t v, input string tag);
        chk({tag, " alu_2id_res"},     alu_2id_res,                v.e_res);
        chk({tag, " alu_2id_hilo"},    alu_2id_hilo,               v.e_hi);
        chk({tag, " exe_alu_des"},     {25'd0, exe_alu_des},       {25'd0, v.e_des});
        chk({tag, " exe_alu_wr_hilo"}, {30'd0, exe_alu_wr_hilo},   {30'd0, v.e_whilo});
    endtask

    task automatic check_reg(input vec_t v, input string tag);
        chk({tag, " exe_res"},        exe_res,                     v.e_res);
        chk({tag, " mem_hilo"},       mem_hilo,                    v.e_hi);
        chk({tag, " mem_data"},       mem_data,                    v.b);
        chk({tag, " mem_pc"},         mem_pc,                      v.pc);
        chk({tag, " exe_contr_word"}, exe_contr_word,              v.cw);
        chk({tag, " exe_int"},        {24'd0, exe_int_contr_word}, {24'd0, v.e_int});
        chk({tag, " exe_des"},        {25'd0, exe_des},            {25'd0, v.e_des});
        chk({tag, " exe_wr_hilo"},    {30'd0, exe_wr_hilo},        {30'd0, v.e_whilo});
    endtask

    task automatic check_reg_zero(input string tag);
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_reg(z, tag);
    endtask

    initial begin
        vec_t v;

        //        cw           a            b            imm          pc           des    hl     intc   res          hi           edes   ewh    eint
        vecs.push_back(mk(32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0040_0000, 7'h25, 2'b00, 8'h00, 32'h0000_0000, 32'h0, 7'h25, 2'b00, 8'h00)); // ADDU wrap
        vecs.push_back(mk(32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h0040_0004, 7'h23, 2'b11, 8'h00, 32'h8000_0000, 32'h0, 7'h03, 2'b00, 8'h04)); // ADD ovf
        vecs.push_back(mk(32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0, 32'h0040_0008, 7'h22, 2'b00, 8'h00, 32'h0000_0002, 32'h0, 7'h22, 2'b00, 8'h00)); // ADD ok
        vecs.push_back(mk(32'h0000_000E, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0040_000C, 7'h00, 2'b11, 8'h00, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 7'h00, 2'b11, 8'h00)); // MULT
        vecs.push_back(mk(32'h0000_000F, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0040_0010, 7'h00, 2'b11, 8'h00, 32'hFFFF_FFFA, 32'h0000_0002, 7'h00, 2'b11, 8'h00)); // MULTU
        vecs.push_back(mk(32'h0000_0080, 32'h0000_1000, 32'h0000_DEAD, 32'hFFFF_FFFC, 32'h0040_0014, 7'h68, 2'b00, 8'h00, 32'h0000_0FFC, 32'h0, 7'h68, 2'b00, 8'h00)); // load
        vecs.push_back(mk(32'h0000_0106, 32'h0000_2000, 32'h0000_BEEF, 32'h0000_0010, 32'h0040_0018, 7'h00, 2'b00, 8'h00, 32'h0000_2010, 32'h0, 7'h00, 2'b00, 8'h00)); // store
        vecs.push_back(mk(32'h0000_1001, 32'h0000_1234, 32'h0000_0001, 32'h0, 32'hBFC0_0000, 7'h3F, 2'b00, 8'h00, 32'hBFC0_0008, 32'h0, 7'h3F, 2'b00, 8'h00)); // link
        vecs.push_back(mk(32'h0000_000C, 32'h0000_0000, 32'h8000_0000, 32'h0000_0100, 32'h0040_0020, 7'h21, 2'b00, 8'h00, 32'hF800_0000, 32'h0, 7'h21, 2'b00, 8'h00)); // SRA
        vecs.push_back(mk(32'h0000_0009, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0040_0024, 7'h21, 2'b00, 8'h00, 32'h0000_0001, 32'h0, 7'h21, 2'b00, 8'h00)); // SLTU
        vecs.push_back(mk(32'h0000_0008, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0040_0028, 7'h21, 2'b00, 8'h00, 32'h0000_0000, 32'h0, 7'h21, 2'b00, 8'h00)); // SLT
        vecs.push_back(mk(32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0040_002C, 7'h3F, 2'b01, 8'h01, 32'h7FFF_FFFF, 32'h0, 7'h1F, 2'b00, 8'h05)); // SUB ovf
        vecs.push_back(mk(32'h0000_0003, 32'h0000_0005, 32'h0000_0007, 32'h0, 32'h0040_0030, 7'h24, 2'b00, 8'h00, 32'hFFFF_FFFE, 32'h0, 7'h24, 2'b00, 8'h00)); // SUBU
        vecs.push_back(mk(32'h0000_0024, 32'hF0F0_F0F0, 32'h0000_0000, 32'h0000_FFFF, 32'h0040_0034, 7'h24, 2'b00, 8'h00, 32'h0000_F0F0, 32'h0, 7'h24, 2'b00, 8'h00)); // ANDI
        vecs.push_back(mk(32'h0000_0005, 32'hF0F0_0000, 32'h0000_000F, 32'h0, 32'h0040_0038, 7'h24, 2'b00, 8'h00, 32'hF0F0_000F, 32'h0, 7'h24, 2'b00, 8'h00)); // OR
        vecs.push_back(mk(32'h0000_0006, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'h0040_003C, 7'h24, 2'b00, 8'h00, 32'hF0F0_0F0F, 32'h0, 7'h24, 2'b00, 8'h00)); // XOR
        vecs.push_back(mk(32'h0000_0007, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0, 32'h0040_0040, 7'h24, 2'b00, 8'h00, 32'hF0F0_F0F0, 32'h0, 7'h24, 2'b00, 8'h00)); // NOR
        vecs.push_back(mk(32'h0000_004A, 32'h0000_0004, 32'h0000_0001, 32'h0, 32'h0040_0044, 7'h24, 2'b00, 8'h00, 32'h0000_0010, 32'h0, 7'h24, 2'b00, 8'h00)); // SLLV
        vecs.push_back(mk(32'h0000_004B, 32'h0000_001F, 32'h8000_0000, 32'h0, 32'h0040_0048, 7'h24, 2'b00, 8'h00, 32'h0000_0001, 32'h0, 7'h24, 2'b00, 8'h00)); // SRLV
        vecs.push_back(mk(32'h0000_000D, 32'h0000_0000, 32'h0000_0000, 32'h0000_1234, 32'h0040_004C, 7'h24, 2'b00, 8'h00, 32'h1234_0000, 32'h0, 7'h24, 2'b00, 8'h00)); // LUI
        vecs.push_back(mk(32'h0000_0010, 32'hCAFE_BABE, 32'h0000_0000, 32'h0, 32'h0040_0050, 7'h24, 2'b00, 8'h00, 32'hCAFE_BABE, 32'h0, 7'h24, 2'b00, 8'h00)); // PASSA
        vecs.push_back(mk(32'h0000_0011, 32'h1234_5678, 32'h0000_0000, 32'h0, 32'h0040_0054, 7'h00, 2'b10, 8'h00, 32'h0000_0000, 32'h1234_5678, 7'h00, 2'b10, 8'h00)); // MTHI
        vecs.push_back(mk(32'h8000_0014, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0040_0058, 7'h24, 2'b00, 8'h80, 32'h0000_0000, 32'h0, 7'h24, 2'b00, 8'h80)); // undefined op

        // Reset state: registered outputs cleared while reset held
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reg_zero("reset");

        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors: combinational in the same cycle, registered one edge later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_comb(vecs[i], $sformatf("v%0d", i));
            @(posedge clk);
            #1;
            check_reg(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back: each edge captures the instruction presented just before it
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check_reg(vecs[0], "b2b0");
        drive(vecs[3]);
        @(posedge clk);
        #1;
        check_reg(vecs[3], "b2b1");

        // Mid-stream reset: capture discarded, combinational path unaffected
        @(negedge clk);
        v = vecs[11];
        drive(v);
        reset = 1'b1;
        #1;
        check_comb(v, "rst_comb");
        @(posedge clk);
        #1;
        check_reg_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reg(v, "rst_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_contr_word  in  32  decoded control word from ID.
REQ-005 id_int_contr_word  in  8  exception control bits from ID.
REQ-006 exe_pc  in  32  PC of the instruction in EXE.
REQ-007 exe_reg_res_A / exe_reg_res_B  in  32 each  forwarded rs / rt operands.
REQ-008 exe_immed  in  32  extended immediate.
REQ-009 id_des  in  7  destination field: [4:0] register number, [5] reg-write enable, [6] is-load.
REQ-010 id_wr_hilo  in  2  {hi_we, lo_we}.
REQ-011 exe_alu_des  out  7  and  exe_alu_wr_hilo  out  2: combinational, for ID forwarding.
REQ-012 alu_2id_res / alu_2id_hilo  out  32 each: combinational result / HI value, for ID forwarding.
REQ-013 exe_res, mem_data, mem_pc, mem_hilo  out  32 each: registered, to MEM.
REQ-014 exe_contr_word  out  32;  exe_int_contr_word  out  8;  exe_des  out  7;  exe_wr_hilo  out  2: registered, to MEM.

Function
REQ-015 Control word fields: [4:0] alu_op; [5] B-source (0 = exe_reg_res_B, 1 = exe_immed); [6] shift-amount source (0 = immed[10:6], 1 = A[4:0]); [7] mem_read; [8] mem_write; [10:9] mem size; [11] load unsigned; [12] link; [31:13] reserved.
REQ-016 alu_op results (A = exe_reg_res_A, Bs = selected B): 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT signed, 9 SLTU unsigned (result 1/0), 10 SLL, 11 SRL, 12 SRA of exe_reg_res_B by the shift amount, 13 LUI = immed[15:0]<<16, 14 MULT signed, 15 MULTU unsigned, 16 PASSA = A, 17 MTHI; codes 18-31 give result 0.
REQ-017 All 32-bit arithmetic wraps modulo 2^32.
REQ-018 ADD/SUB signed overflow drives bit 2 of the outgoing int control word high; on overflow, des[5] and wr_hilo are cleared both in the forwarding outputs and in the registered outputs.
REQ-019 MULT/MULTU: result = low 32 bits of the 64-bit product, HI value = upper 32 bits.
REQ-020 MTHI: HI value = A and result = 0; for every other op, HI value = 0.
REQ-021 mem_read or mem_write set: result = A + exe_immed, regardless of alu_op.
REQ-022 link set: result = exe_pc + 8, with priority over all other result sources.
REQ-023 alu_2id_res = result; alu_2id_hilo = HI value; exe_alu_des = id_des (with overflow masking); exe_alu_wr_hilo = id_wr_hilo (with overflow masking); all combinational, zero cycles.
REQ-024 On each rising edge with reset low, capture exactly one cycle after the inputs:
  - exe_res = result
  - mem_hilo = HI value
  - mem_data = exe_reg_res_B
  - mem_pc = exe_pc
  - exe_contr_word = id_contr_word, unchanged
  - exe_int_contr_word = id_int_contr_word OR overflow bit
  - exe_des = masked des
  - exe_wr_hilo = masked wr_hilo
REQ-025 No stall and no flush inputs; the stage accepts a new instruction every cycle.

Reset
REQ-026 reset high at a rising edge forces every registered output to 0, with priority over capture; combinational outputs still follow the inputs.
REQ-027 A reset asserted mid-stream discards the instruction being captured; the first post-reset capture happens on the first edge with reset low.

Structure
REQ-028 alu_op codes, control-word bit positions and des field positions SHALL live in a shared package, exe_pkg, used by the ID stages.
REQ-029 The combinational datapath SHALL be a single sub-module, exe_alu; exe_stage holds only the masking logic and the pipeline register.

Verification
REQ-030 ADDU, A=0xFFFFFFFF, B=1, id_des=0x25 -> alu_2id_res=0 in the same cycle; one edge later exe_res=0, exe_des=0x25.
REQ-031 ADD, A=0x7FFFFFFF, B=1, id_des=0x23 -> exe_int_contr_word bit2=1, exe_des=0x03, exe_alu_des=0x03.
REQ-032 MULT, A=0xFFFFFFFE (-2), B=3, id_wr_hilo=11 -> exe_res=0xFFFFFFFA, mem_hilo=0xFFFFFFFF, exe_wr_hilo=11.
REQ-033 Load with mem_read=1, A=0x1000, immed=0xFFFFFFFC, B=0xDEAD -> exe_res=0x0FFC, mem_data=0xDEAD; with link=1 and exe_pc=0xBFC00000 -> exe_res=0xBFC00008.
REQ-034 SRA, B=0x80000000, immed[10:6]=4 -> 0xF8000000; SLTU, A=1, B=0xFFFFFFFF -> 1; SLT, same operands -> 0.
REQ-035 reset asserted while valid inputs are held -> all registered outputs 0 on the next edge; outputs match the inputs one edge after reset deasserts.
